// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges primary and queued long-latency results onto the register-file write port
// and tracks per-register busy bits for RAW stalls. Optional same-edge bypass via WB_BYPASS_EN.
module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     PriWr,
    input  logic [4:0]               PriRW,
    input  logic [DW-1:0]            PriData,
    input  logic                     LlValid,
    input  logic [4:0]               LlRW,
    input  logic [DW-1:0]            LlData,
    output logic                     LlReady,
    input  logic                     IssueLl,
    input  logic [4:0]               IssueRW,
    input  logic [4:0]               RA,
    input  logic [4:0]               RB,
    output logic                     HazA,
    output logic                     HazB,
    output logic                     RegWr,
    output logic [4:0]               RW,
    output logic [DW-1:0]            BusW,
    output logic [$clog2(DEPTH):0]   QCount,
    output logic                     ErrWaw
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [4:0] XZR   = 5'd31;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO = (AW+1)'(0);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [4:0]    qRw_r   [DEPTH];
    logic [DW-1:0] qData_r [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [AW:0]   count_r;
    logic [31:0]   busy_r;
    logic          err_r;
    logic          regWr_r;
    logic [4:0]    rw_r;
    logic [DW-1:0] busW_r;

    logic          priReq_s;
    logic          issue_s;
    logic          ready_s;
    logic          accept_s;
    logic          empty_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [4:0]    headRw_s;
    logic [DW-1:0] headData_s;
    logic          wrNext_s;
    logic [4:0]    rwNext_s;
    logic [DW-1:0] busWNext_s;
    logic [31:0]   setMask_s;
    logic [31:0]   clrMask_s;
    logic [AW:0]   countNext_s;
    logic          errSet_s;

    // Register 31 is hard-wired zero, so any request naming it is discarded up front.
    assign priReq_s   = PriWr && (PriRW != XZR);
    assign issue_s    = IssueLl && (IssueRW != XZR);
    assign ready_s    = !Reset && (count_r != FULL);
    assign accept_s   = LlValid && ready_s && (LlRW != XZR);
    assign empty_s    = (count_r == ZERO);
    assign headRw_s   = qRw_r[rdPtr_r];
    assign headData_s = qData_r[rdPtr_r];
`ifdef WB_BYPASS_EN
    assign bypass_s   = empty_s && !priReq_s && accept_s;
`else
    assign bypass_s   = 1'b0;
`endif
    assign push_s     = accept_s && !bypass_s;
    assign pop_s      = !priReq_s && !empty_s;

    assign LlReady = ready_s;
    assign HazA    = (RA != XZR) && busy_r[RA];
    assign HazB    = (RB != XZR) && busy_r[RB];
    assign RegWr   = regWr_r;
    assign RW      = rw_r;
    assign BusW    = busW_r;
    assign QCount  = count_r;
    assign ErrWaw  = err_r;

    // Write-port source selection: primary, then queue head, then same-edge bypass.
    always_comb begin
        wrNext_s   = 1'b0;
        rwNext_s   = rw_r;
        busWNext_s = busW_r;
        if (priReq_s) begin
            wrNext_s   = 1'b1;
            rwNext_s   = PriRW;
            busWNext_s = PriData;
        end else if (pop_s) begin
            wrNext_s   = 1'b1;
            rwNext_s   = headRw_s;
            busWNext_s = headData_s;
        end else if (bypass_s) begin
            wrNext_s   = 1'b1;
            rwNext_s   = LlRW;
            busWNext_s = LlData;
        end else begin
            wrNext_s   = 1'b0;
        end
    end

    // Scoreboard masks; set is applied after clear so a same-cycle issue keeps the bit busy.
    always_comb begin
        clrMask_s = 32'd0;
        setMask_s = 32'd0;
        if (pop_s) begin
            clrMask_s[headRw_s] = 1'b1;
        end else if (bypass_s) begin
            clrMask_s[LlRW] = 1'b1;
        end else begin
            clrMask_s = 32'd0;
        end
        if (issue_s) begin
            setMask_s[IssueRW] = 1'b1;
        end else begin
            setMask_s = 32'd0;
        end
    end

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + ONE;
            2'b01:   countNext_s = count_r - ONE;
            default: countNext_s = count_r;
        endcase
    end

    assign errSet_s = (priReq_s && busy_r[PriRW]) || (issue_s && busy_r[IssueRW]);

    // Control state: pointers, count, busy bits, sticky error and the registered write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= ZERO;
            busy_r  <= 32'd0;
            err_r   <= 1'b0;
            regWr_r <= 1'b0;
            rw_r    <= XZR;
            busW_r  <= {DW{1'b0}};
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r <= countNext_s;
            busy_r  <= (busy_r & ~clrMask_s) | setMask_s;
            err_r   <= err_r | errSet_s;
            regWr_r <= wrNext_s;
            rw_r    <= rwNext_s;
            busW_r  <= busWNext_s;
        end
    end

    // Queue payload storage; contents are meaningless outside the occupied window, so no reset.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            qRw_r[wrPtr_r]   <= LlRW;
            qData_r[wrPtr_r] <= LlData;
        end
    end

endmodule
